// File: rtl/mcd_mem_arbiter.sv
// Shared DRAM arbiter: fixed-priority display channels plus round-robin for the
// rest, funnelled into one word-wide RAM port with byte enables and read latency.
module mcd_mem_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int NUM_FIXED    = 2,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_CH-1:0]              req,
    input  logic [NUM_CH-1:0]              we,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   be,
    input  logic [NUM_CH*ADDR_W-1:0]       addr,
    input  logic [NUM_CH*DATA_W-1:0]       wdata,
    output logic [NUM_CH-1:0]              ack,
    output logic [DATA_W-1:0]              rdata,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [DATA_W/8-1:0]            mem_be,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic                           busy
);
    localparam int BE_W   = DATA_W / 8;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = $clog2(NUM_CH + 1);
    localparam int NUM_RR = NUM_CH - NUM_FIXED;
    localparam int LAT_W  = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                          state, state_n;
    logic [NUM_CH-1:0][ADDR_W-1:0]   addr_a;
    logic [NUM_CH-1:0][DATA_W-1:0]   wdata_a;
    logic [NUM_CH-1:0][BE_W-1:0]     be_a;

    logic [IDX_W-1:0]  win, gnt_q;
    logic              win_vld;
    logic [PTR_W-1:0]  rr_ptr;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  lat_cnt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
        assign be_a[i]    = be[i*BE_W +: BE_W];
    end

    // Fixed channels scanned high-to-low so the lowest index wins; the round-robin
    // window is scanned from the far end back to rr_ptr for the same effect.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int i = NUM_FIXED - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win     = IDX_W'(i);
            end
        end
        if (!win_vld) begin
            for (int k = NUM_RR - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_RR;
                if (req[idx]) begin
                    win_vld = 1'b1;
                    win     = IDX_W'(idx);
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (win_vld) state_n = ISSUE;
            ISSUE:   state_n = we_q ? DONE : WAIT;
            WAIT:    if (lat_cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_cnt <= '0;
            rdata   <= '0;
            rr_ptr  <= PTR_W'(NUM_FIXED);
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (win_vld) begin
                    gnt_q   <= win;
                    we_q    <= we[win];
                    be_q    <= be_a[win];
                    addr_q  <= addr_a[win];
                    wdata_q <= wdata_a[win];
                end
                ISSUE: lat_cnt <= LAT_W'(READ_LATENCY - 1);
                WAIT: begin
                    if (lat_cnt == '0) rdata <= mem_rdata;
                    else               lat_cnt <= lat_cnt - 1'b1;
                end
                DONE: if (int'(gnt_q) >= NUM_FIXED) begin
                    if (int'(gnt_q) == NUM_CH - 1) rr_ptr <= PTR_W'(NUM_FIXED);
                    else                           rr_ptr <= PTR_W'(gnt_q) + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory-side outputs are gated by state so they collapse the moment reset hits.
    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_be    = mem_en ? be_q    : '0;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign ack       = (state == DONE) ? (NUM_CH'(1) << gnt_q) : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mcd_mem_arbiter.sv
// Directed scoreboard bench for mcd_mem_arbiter with a behavioural RAM of
// read latency RL; expected accesses are queued at drive time and retired on ack.
module tb_mcd_mem_arbiter;
    localparam int NCH = 4, NFX = 2, AW = 19, DW = 16, RL = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NCH-1:0]    req, we, ack;
    logic [NCH*2-1:0]  be;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [DW-1:0]     rdata, mem_rdata, mem_wdata;
    logic              mem_en, mem_we, busy;
    logic [1:0]        mem_be;
    logic [AW-1:0]     mem_addr;

    mcd_mem_arbiter #(.NUM_CH(NCH), .NUM_FIXED(NFX), .ADDR_W(AW), .DATA_W(DW),
                      .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy));

    always #5 clk = ~clk;

    // Behavioural RAM: reloaded while in reset, read data appears RL cycles after mem_en.
    logic [15:0] ram [0:255];
    logic [15:0] rd_pipe [0:RL-1];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            ram[8'h10] <= 16'h1234;
            for (int i = 0; i < RL; i++) rd_pipe[i] <= 16'hDEAD;
        end else begin
            if (mem_en && mem_we) begin
                if (mem_be[0]) ram[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
                if (mem_be[1]) ram[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
            end
            rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:0]] : 16'hDEAD;
            for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[RL-1];

    typedef struct {
        int         ch;
        bit         rd;
        logic [1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int         issue_cyc;
        int         ack_cyc;
    } exp_t;

    exp_t sb[$];
    int   rem [NCH];
    int   n_chk = 0, n_pass = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int ch, input bit wr, input logic [1:0] b,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[ch] = 1'b1;
        we[ch]  = wr;
        be[ch*2 +: 2]     = b;
        addr[ch*AW +: AW] = a;
        wdata[ch*DW +: DW] = d;
    endtask

    task automatic expect_acc(input int ch, input bit rd, input logic [1:0] b,
                              input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [DW-1:0] rd_exp, input int ack_c);
        exp_t e;
        e.ch = ch; e.rd = rd; e.be = b; e.addr = a; e.wdata = d; e.rdata = rd_exp;
        e.ack_cyc   = ack_c;
        e.issue_cyc = ack_c - (rd ? RL + 1 : 1);
        sb.push_back(e);
        rem[ch] = rem[ch] + 1;
    endtask

    // Step cycles until every queued access has acked, then idle one cycle so the
    // next request is first seen by the arbiter in IDLE.
    task automatic run(input int budget);
        exp_t e;
        for (int i = 0; i < budget && sb.size() > 0; i++) begin
            @(posedge clk); cyc = cyc + 1; @(negedge clk);
            chk("busy", {31'b0, busy}, {31'b0, (cyc >= sb[0].issue_cyc)});
            if (mem_en) begin
                e = sb[0];
                chk("issue_cyc", cyc, e.issue_cyc);
                chk("mem_we", {31'b0, mem_we}, {31'b0, !e.rd});
                chk("mem_addr", mem_addr, e.addr);
                if (!e.rd) begin
                    chk("mem_be", mem_be, e.be);
                    chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (ack != '0) begin
                e = sb.pop_front();
                chk("ack_vec", ack, 1 << e.ch);
                chk("ack_cyc", cyc, e.ack_cyc);
                if (e.rd) chk("rdata", rdata, e.rdata);
                rem[e.ch] = rem[e.ch] - 1;
                if (rem[e.ch] == 0) req[e.ch] = 1'b0;
            end
        end
        chk("drain", sb.size(), 0);
        @(posedge clk); @(negedge clk);
        chk("idle_ack", ack, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        for (int i = 0; i < NCH; i++) rem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 0);

        // single write on a round-robin channel
        cyc = 0;
        drive(2, 1'b1, 2'b11, 19'h00123, 16'hA55A);
        expect_acc(2, 1'b0, 2'b11, 19'h00123, 16'hA55A, 16'h0, 2);
        run(20);

        // single read with two-cycle RAM latency
        cyc = 0;
        drive(0, 1'b0, 2'b11, 19'h00010, 16'h0);
        expect_acc(0, 1'b1, 2'b11, 19'h00010, 16'h0, 16'h1234, 2 + RL);
        run(20);

        // fixed channels beat round-robin; ch3 last
        cyc = 0;
        drive(0, 1'b1, 2'b11, 19'h00020, 16'h1111);
        drive(1, 1'b1, 2'b11, 19'h00021, 16'h2222);
        drive(3, 1'b1, 2'b11, 19'h00022, 16'h3333);
        expect_acc(0, 1'b0, 2'b11, 19'h00020, 16'h1111, 16'h0, 2);
        expect_acc(1, 1'b0, 2'b11, 19'h00021, 16'h2222, 16'h0, 5);
        expect_acc(3, 1'b0, 2'b11, 19'h00022, 16'h3333, 16'h0, 8);
        run(40);

        // round-robin alternation with both channels holding req
        cyc = 0;
        drive(2, 1'b1, 2'b11, 19'h00030, 16'hC2C2);
        drive(3, 1'b1, 2'b11, 19'h00031, 16'hC3C3);
        expect_acc(2, 1'b0, 2'b11, 19'h00030, 16'hC2C2, 16'h0, 2);
        expect_acc(3, 1'b0, 2'b11, 19'h00031, 16'hC3C3, 16'h0, 5);
        expect_acc(2, 1'b0, 2'b11, 19'h00030, 16'hC2C2, 16'h0, 8);
        expect_acc(3, 1'b0, 2'b11, 19'h00031, 16'hC3C3, 16'h0, 11);
        run(40);

        // upper byte lane only, then read back
        cyc = 0;
        drive(1, 1'b1, 2'b10, 19'h00040, 16'hBEEF);
        expect_acc(1, 1'b0, 2'b10, 19'h00040, 16'hBEEF, 16'h0, 2);
        run(20);
        cyc = 0;
        drive(1, 1'b0, 2'b11, 19'h00040, 16'h0);
        expect_acc(1, 1'b1, 2'b11, 19'h00040, 16'h0, 16'hBE00, 2 + RL);
        run(20);

        // be==0 write still cycles the RAM but changes nothing; rdata holds
        cyc = 0;
        drive(3, 1'b1, 2'b00, 19'h00040, 16'hFFFF);
        expect_acc(3, 1'b0, 2'b00, 19'h00040, 16'hFFFF, 16'h0, 2);
        run(20);
        chk("rdata_hold", rdata, 16'hBE00);
        cyc = 0;
        drive(0, 1'b0, 2'b11, 19'h00040, 16'h0);
        expect_acc(0, 1'b1, 2'b11, 19'h00040, 16'h0, 16'hBE00, 2 + RL);
        run(20);

        // reset while waiting on read data
        drive(0, 1'b0, 2'b11, 19'h00010, 16'h0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_mem_en", {31'b0, mem_en}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_rdata", rdata, 0);
        req = '0;
        for (int i = 0; i < NCH; i++) rem[i] = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("no_ack_after_rst", ack, 0);
        cyc = 0;
        drive(1, 1'b0, 2'b11, 19'h00010, 16'h0);
        expect_acc(1, 1'b1, 2'b11, 19'h00010, 16'h0, 16'h1234, 2 + RL);
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
